hud_game_sequencer: RTL

- Game-flow controller for the HUD layer mux: IDLE -> countdown -> play -> life-lost blink -> game over.
- Owns the lives count, level number and countdown digit.
- Drives per-layer visibility enables that gate each HUD drawer's drawing request before the mux.
- Advances once per video frame using the frame-start strobe; all outputs are registered.

---
 rtl/hud_game_sequencer.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/hud_game_sequencer.sv
// hud_game_sequencer: game-flow controller for the HUD layer mux.
// Walks IDLE -> COUNTDOWN -> PLAY -> LIFE_LOST blink -> GAME_OVER. It owns the
// lives count, the level number and the countdown digit, and it drives the
// per-layer visibility enables. Counting steps once per video frame on
// startOfFrame, and every output comes straight from a register.
// Optional feature: define HUD_SEQ_PAUSE_EN to add the pauseToggle input, the
// paused output and a PAUSED state.
module hud_game_sequencer #(
    parameter int unsigned FRAMES_PER_COUNT = 60,
    parameter int unsigned START_LIVES      = 3,
    parameter int unsigned BLINK_FRAMES     = 8,
    parameter int unsigned BLINK_TOGGLES    = 6,
    parameter int unsigned MAX_LEVEL        = 99
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       startOfFrame,
    input  logic       startGame,
    input  logic       hitEvent,
    input  logic       levelUp,
`ifdef HUD_SEQ_PAUSE_EN
    input  logic       pauseToggle,
    output logic       paused,
`endif
    output logic [5:0] layerEnable,
    output logic [1:0] countdownDigit,
    output logic [2:0] livesCount,
    output logic [6:0] levelNum,
    output logic       playEnable,
    output logic       gameOver
);

    localparam int unsigned FMAX = (FRAMES_PER_COUNT > BLINK_FRAMES) ? FRAMES_PER_COUNT : BLINK_FRAMES;
    localparam int unsigned FCW  = ($clog2(FMAX) < 1) ? 1 : $clog2(FMAX);
    localparam int unsigned BCW  = ($clog2(BLINK_TOGGLES + 1) < 1) ? 1 : $clog2(BLINK_TOGGLES + 1);

    localparam logic [FCW-1:0] COUNT_LAST  = FCW'(FRAMES_PER_COUNT - 1);
    localparam logic [FCW-1:0] BLINK_LAST  = FCW'(BLINK_FRAMES - 1);
    localparam logic [BCW-1:0] TOGGLE_LAST = BCW'(BLINK_TOGGLES - 1);
    localparam logic [2:0]     LIVES_INIT  = 3'(START_LIVES);
    localparam logic [6:0]     LEVEL_MAX   = 7'(MAX_LEVEL);

    localparam logic [5:0] LE_NORMAL    = 6'b011111;
    localparam logic [5:0] LE_COUNTDOWN = 6'b111111;
    localparam logic [5:0] LE_GAMEOVER  = 6'b011011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNTDOWN,
        S_PLAY,
        S_LIFE_LOST,
        S_GAME_OVER
`ifdef HUD_SEQ_PAUSE_EN
        , S_PAUSED
`endif
    } state_t;

    state_t           state_q, state_d;
    logic [FCW-1:0]   frame_q, frame_d;
    logic [BCW-1:0]   blink_q, blink_d;
    logic [1:0]       digit_q, digit_d;
    logic [2:0]       lives_q, lives_d;
    logic [6:0]       level_q, level_d;
    logic             heart_q, heart_d;
    logic [5:0]       le_q, le_d;
    logic             play_q, play_d;
    logic             go_q, go_d;
    logic [6:0]       level_inc;
`ifdef HUD_SEQ_PAUSE_EN
    state_t           prior_q, prior_d;
    logic             paused_q, paused_d;
`endif

    assign level_inc = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 7'd1;

    // Next-state, counter updates and registered-output values.
    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        blink_d = blink_q;
        digit_d = digit_q;
        lives_d = lives_q;
        level_d = level_q;
        heart_d = heart_q;
`ifdef HUD_SEQ_PAUSE_EN
        prior_d = prior_q;
`endif
        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (startGame) begin
                    state_d = S_COUNTDOWN;
                    digit_d = 2'd3;
                    frame_d = '0;
                    blink_d = '0;
                    heart_d = 1'b1;
                    lives_d = LIVES_INIT;
                    level_d = 7'd1;
                end
            end
            S_COUNTDOWN: begin
                if (startOfFrame) begin
                    if (frame_q == COUNT_LAST) begin
                        frame_d = '0;
                        if (digit_q != 2'd0) begin
                            digit_d = digit_q - 2'd1;
                        end else begin
                            state_d = S_PLAY;
                        end
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end
            S_PLAY: begin
                if (hitEvent) begin
                    if (lives_q > 3'd1) begin
                        lives_d = lives_q - 3'd1;
                        state_d = S_LIFE_LOST;
                        blink_d = '0;
                        frame_d = '0;
                        heart_d = 1'b0;
                    end else begin
                        lives_d = 3'd0;
                        state_d = S_GAME_OVER;
                    end
                end else if (levelUp) begin
                    level_d = level_inc;
                    state_d = S_COUNTDOWN;
                    digit_d = 2'd3;
                    frame_d = '0;
                end
            end
            S_LIFE_LOST: begin
                if (levelUp) begin
                    level_d = level_inc;
                    state_d = S_COUNTDOWN;
                    digit_d = 2'd3;
                    frame_d = '0;
                    blink_d = '0;
                    heart_d = 1'b1;
                end else if (startOfFrame) begin
                    if (frame_q == BLINK_LAST) begin
                        frame_d = '0;
                        heart_d = ~heart_q;
                        if (blink_q == TOGGLE_LAST) begin
                            blink_d = '0;
                            state_d = S_PLAY;
                        end else begin
                            blink_d = blink_q + 1'b1;
                        end
                    end else begin
                        frame_d = frame_q + 1'b1;
                    end
                end
            end
`ifdef HUD_SEQ_PAUSE_EN
            S_PAUSED: begin
            end
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef HUD_SEQ_PAUSE_EN
        // A pause request overrides every other update so the counters freeze exactly.
        if (pauseToggle) begin
            if (state_q == S_COUNTDOWN || state_q == S_PLAY || state_q == S_LIFE_LOST) begin
                state_d = S_PAUSED;
                prior_d = state_q;
                frame_d = frame_q;
                blink_d = blink_q;
                digit_d = digit_q;
                lives_d = lives_q;
                level_d = level_q;
                heart_d = heart_q;
            end else if (state_q == S_PAUSED) begin
                state_d = prior_q;
            end
        end
`endif

        case (state_d)
            S_COUNTDOWN: le_d = LE_COUNTDOWN;
            S_PLAY:      le_d = LE_NORMAL;
            S_LIFE_LOST: le_d = {3'b011, heart_d, 2'b11};
            S_GAME_OVER: le_d = LE_GAMEOVER;
`ifdef HUD_SEQ_PAUSE_EN
            S_PAUSED:    le_d = le_q;
`endif
            default:     le_d = LE_NORMAL;
        endcase
        play_d = (state_d == S_PLAY) || (state_d == S_LIFE_LOST);
        go_d   = (state_d == S_GAME_OVER);
`ifdef HUD_SEQ_PAUSE_EN
        paused_d = (state_d == S_PAUSED);
`endif
    end

    // State, counters and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_IDLE;
            frame_q <= '0;
            blink_q <= '0;
            digit_q <= 2'd3;
            lives_q <= LIVES_INIT;
            level_q <= 7'd1;
            heart_q <= 1'b1;
            le_q    <= LE_NORMAL;
            play_q  <= 1'b0;
            go_q    <= 1'b0;
`ifdef HUD_SEQ_PAUSE_EN
            prior_q  <= S_IDLE;
            paused_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            blink_q <= blink_d;
            digit_q <= digit_d;
            lives_q <= lives_d;
            level_q <= level_d;
            heart_q <= heart_d;
            le_q    <= le_d;
            play_q  <= play_d;
            go_q    <= go_d;
`ifdef HUD_SEQ_PAUSE_EN
            prior_q  <= prior_d;
            paused_q <= paused_d;
`endif
        end
    end

    assign layerEnable    = le_q;
    assign countdownDigit = digit_q;
    assign livesCount     = lives_q;
    assign levelNum       = level_q;
    assign playEnable     = play_q;
    assign gameOver       = go_q;
`ifdef HUD_SEQ_PAUSE_EN
    assign paused         = paused_q;
`endif

endmodule
